// File: rtl/zero_array_heap.sv
// zero_array_heap: clocked array heap with a LIFO free stack, per-array
// length tracking, an allocation bitmap and a multi-cycle array clear.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. The requester holds req_* stable while req_valid
// is high and req_ready is low. Every transferred request gets exactly one
// rsp_valid pulse (one cycle after transfer, or NAREA cycles for a
// successful CLEAR). rsp_data/rsp_error hold between pulses.
module zero_array_heap #(
  parameter int WIDTH   = 12,
  parameter int NAREA   = 7,
  parameter int NARRAYS = 4,
  parameter int AW      = (NARRAYS > 1) ? $clog2(NARRAYS) : 1,
  parameter int IW      = (NAREA > 1) ? $clog2(NAREA) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [AW-1:0]    req_array,
  input  logic [IW-1:0]    req_index,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic [AW:0]      allocs,
  output logic [AW:0]      free_count,
  output logic [0:0]       fsm_state
);

  // Storage is sized to the full power-of-two array-number range so any
  // req_array value indexes a real slot; slots >= NARRAYS are never allocated.
  localparam int NSLOT = 1 << AW;
  localparam int SW    = $clog2(NAREA + 1);
  localparam int DEPTH = NSLOT * NAREA;
  localparam int HW    = $clog2(DEPTH);

  localparam logic [AW:0] MAX_ARR = (AW + 1)'(NARRAYS);
  localparam logic [IW:0] MAX_IDX = (IW + 1)'(NAREA);

  localparam logic [2:0] OP_ALLOC = 3'd0;
  localparam logic [2:0] OP_FREE  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_SIZE  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  localparam logic [2:0] OP_ADD   = 3'd6;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEARING = 1'b1;

  logic [0:0]       state_q;
  logic             ready_q;
  logic [IW-1:0]    clr_cnt;
  logic [AW-1:0]    clr_array;
  logic [NSLOT-1:0] allocated;
  logic [SW-1:0]    size_q  [NSLOT];
  logic [AW-1:0]    stack_q [NSLOT];
  logic [WIDTH-1:0] heap    [DEPTH];
  logic [AW:0]      allocs_q;
  logic [AW:0]      free_q;

  logic             accept;
  logic             arr_valid;
  logic             idx_ok;
  logic [SW-1:0]    cur_size;
  logic [SW-1:0]    idx_plus;
  logic [SW-1:0]    grown;
  logic [HW-1:0]    req_addr;
  logic [HW-1:0]    clr_addr;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] sum;
  logic [AW-1:0]    pop_num;
  logic [AW-1:0]    alloc_num;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             heap_we;
  logic [HW-1:0]    heap_addr;
  logic [WIDTH-1:0] heap_wdata;

  assign req_ready  = ready_q;
  assign allocs     = allocs_q;
  assign free_count = free_q;
  assign fsm_state  = state_q;

  // Request decode: address, range checks, size growth and ALLOC source.
  always_comb begin
    accept    = req_valid && ready_q;
    arr_valid = ({1'b0, req_array} < MAX_ARR) && allocated[req_array];
    idx_ok    = ({1'b0, req_index} < MAX_IDX);
    cur_size  = size_q[req_array];
    idx_plus  = SW'(req_index) + SW'(1);
    grown     = (idx_plus > cur_size) ? idx_plus : cur_size;
    req_addr  = HW'(req_array) * HW'(NAREA) + HW'(req_index);
    clr_addr  = HW'(clr_array) * HW'(NAREA) + HW'(clr_cnt);
    rd_val    = heap[req_addr];
    sum       = rd_val + req_data;
    pop_num   = stack_q[AW'(free_q - (AW + 1)'(1))];
    alloc_num = (free_q != '0) ? pop_num : allocs_q[AW-1:0];
  end

  // Per-op error classification and response value (0 on any error).
  always_comb begin
    err    = 1'b0;
    result = '0;
    case (req_op)
      OP_ALLOC: begin
        err    = (free_q == '0) && (allocs_q == MAX_ARR);
        result = WIDTH'(alloc_num);
      end
      OP_FREE:  err = !arr_valid;
      OP_WRITE: begin
        err    = !arr_valid || !idx_ok;
        result = req_data;
      end
      OP_READ: begin
        err    = !arr_valid || !idx_ok;
        result = rd_val;
      end
      OP_ADD: begin
        err    = !arr_valid || !idx_ok;
        result = sum;
      end
      OP_SIZE: begin
        err    = !arr_valid;
        result = WIDTH'(cur_size);
      end
      OP_CLEAR: err = !arr_valid;
      default:  err = 1'b1;
    endcase
    if (err) result = '0;
  end

  // Single heap write port: clear sweep has priority, otherwise WRITE/ADD.
  always_comb begin
    heap_we    = 1'b0;
    heap_addr  = req_addr;
    heap_wdata = req_data;
    if (state_q == CLEARING) begin
      heap_we    = 1'b1;
      heap_addr  = clr_addr;
      heap_wdata = '0;
    end else if (accept && !err && req_op == OP_WRITE) begin
      heap_we = 1'b1;
    end else if (accept && !err && req_op == OP_ADD) begin
      heap_we    = 1'b1;
      heap_wdata = sum;
    end
  end

  // Heap and free-stack storage; contents survive reset by design.
  always_ff @(posedge clock) begin
    if (heap_we) heap[heap_addr] <= heap_wdata;
    if (accept && !err && req_op == OP_FREE) stack_q[AW'(free_q)] <= req_array;
  end

  // Control state, FSM and registered response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      clr_cnt   <= '0;
      clr_array <= '0;
      allocated <= '0;
      allocs_q  <= '0;
      free_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      for (int i = 0; i < NSLOT; i++) size_q[i] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (req_op == OP_CLEAR && !err) begin
              state_q           <= CLEARING;
              ready_q           <= 1'b0;
              clr_cnt           <= '0;
              clr_array         <= req_array;
              size_q[req_array] <= '0;
            end else begin
              rsp_valid <= 1'b1;
              rsp_error <= err;
              rsp_data  <= result;
              if (!err) begin
                case (req_op)
                  OP_ALLOC: begin
                    size_q[alloc_num]    <= '0;
                    allocated[alloc_num] <= 1'b1;
                    if (free_q != '0) free_q <= free_q - 1'b1;
                    else allocs_q <= allocs_q + 1'b1;
                  end
                  OP_FREE: begin
                    allocated[req_array] <= 1'b0;
                    free_q               <= free_q + 1'b1;
                  end
                  OP_WRITE, OP_ADD: size_q[req_array] <= grown;
                  default: ;
                endcase
              end
            end
          end
        end
        CLEARING: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IW'(NAREA - 1)) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_array_heap.sv
// Directed bench for zero_array_heap: drivers push expected responses into a
// queue; a negedge monitor pops and compares whenever rsp_valid is high.
module tb_zero_array_heap;
  localparam int WIDTH   = 12;
  localparam int NAREA   = 7;
  localparam int NARRAYS = 4;
  localparam int AW      = 2;
  localparam int IW      = 3;

  localparam logic [2:0] OP_ALLOC = 3'd0;
  localparam logic [2:0] OP_FREE  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_SIZE  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  localparam logic [2:0] OP_ADD   = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [AW-1:0]    req_array;
  logic [IW-1:0]    req_index;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic [AW:0]      allocs;
  logic [AW:0]      free_count;
  logic [0:0]       fsm_state;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  zero_array_heap #(.WIDTH(WIDTH), .NAREA(NAREA), .NARRAYS(NARRAYS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_array(req_array), .req_index(req_index), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .allocs(allocs), .free_count(free_count), .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // Drive one request; push its expected {error,data} when it will be taken.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] arr,
                       input logic [IW-1:0] idx, input logic [WIDTH-1:0] data,
                       input logic e_err, input logic [WIDTH-1:0] e_data);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = op;
    req_array = arr;
    req_index = idx;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_ready: got ready=0 required ready=1 (op %0d)", op);
      req_valid = 1'b0;
    end else begin
      exp_q.push_back({e_err, e_data});
      @(posedge clock);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      req_valid = 1'b0;
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got err=%0b data=%0h required no response", rsp_error, rsp_data);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        if ({rsp_error, rsp_data} !== e)
          $display("FAIL rsp: got err=%0b data=%0h required err=%0b data=%0h",
                   rsp_error, rsp_data, e[WIDTH], e[WIDTH-1:0]);
        if ({rsp_error, rsp_data} !== e) errors++;
      end
    end
  end

  initial begin
    int low_cnt;
    int rsp_edge;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_array = '0;
    req_index = '0;
    req_data  = '0;

    // Reset values.
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_error", 32'(rsp_error), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_allocs", 32'(allocs), 0);
    check("rst_free", 32'(free_count), 0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("ready_before_edge", 32'(req_ready), 0);
    @(negedge clock);
    check("ready_after_edge", 32'(req_ready), 1);

    // Allocation order and exhaustion.
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd2);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd3);
    idle(1);
    check("allocs_4", 32'(allocs), 4);
    issue(OP_ALLOC, 0, 0, 0, 1'b1, 12'd0);
    idle(1);
    check("allocs_stay_4", 32'(allocs), 4);
    check("free_0", 32'(free_count), 0);

    // LIFO reuse and double free.
    issue(OP_FREE, 1, 0, 0, 1'b0, 12'd0);
    issue(OP_FREE, 3, 0, 0, 1'b0, 12'd0);
    idle(1);
    check("free_2", 32'(free_count), 2);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd3);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1);
    idle(1);
    check("free_0_again", 32'(free_count), 0);
    issue(OP_FREE, 1, 0, 0, 1'b0, 12'd0);
    issue(OP_FREE, 1, 0, 0, 1'b1, 12'd0);
    idle(1);
    check("free_1_after_double", 32'(free_count), 1);

    // Data ops on an unallocated array, and the reserved op.
    issue(OP_READ, 1, 0, 0, 1'b1, 12'd0);
    issue(OP_SIZE, 1, 0, 0, 1'b1, 12'd0);
    issue(OP_WRITE, 1, 0, 12'h123, 1'b1, 12'd0);
    issue(OP_CLEAR, 1, 0, 0, 1'b1, 12'd0);
    idle(1);
    check("clear_err_valid", 32'(rsp_valid), 1);
    check("clear_err_flag", 32'(rsp_error), 1);
    check("clear_err_ready", 32'(req_ready), 1);
    issue(OP_RSVD, 0, 0, 0, 1'b1, 12'd0);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1);
    idle(1);
    check("free_0_realloc", 32'(free_count), 0);

    // Size tracking and index bounds.
    issue(OP_SIZE, 0, 0, 0, 1'b0, 12'd0);
    issue(OP_WRITE, 0, 2, 12'd7, 1'b0, 12'd7);
    issue(OP_SIZE, 0, 0, 0, 1'b0, 12'd3);
    issue(OP_WRITE, 0, 0, 12'd0, 1'b0, 12'd0);
    issue(OP_SIZE, 0, 0, 0, 1'b0, 12'd3);
    issue(OP_WRITE, 0, 6, 12'd5, 1'b0, 12'd5);
    issue(OP_SIZE, 0, 0, 0, 1'b0, 12'd7);
    issue(OP_READ, 0, 7, 0, 1'b1, 12'd0);
    issue(OP_ADD, 0, 7, 12'd1, 1'b1, 12'd0);
    issue(OP_READ, 0, 2, 0, 1'b0, 12'd7);

    // ADD wrap with back-to-back read.
    issue(OP_WRITE, 0, 1, 12'hFFF, 1'b0, 12'hFFF);
    issue(OP_ADD, 0, 1, 12'd2, 1'b0, 12'h001);
    issue(OP_READ, 0, 1, 0, 1'b0, 12'h001);

    // CLEAR timing.
    issue(OP_CLEAR, 0, 0, 0, 1'b0, 12'd0);
    low_cnt  = 0;
    rsp_edge = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (i == 1) check("clear_state", 32'(fsm_state), 1);
      if (!req_ready) low_cnt++;
      if (rsp_valid && rsp_edge < 0) rsp_edge = i - 1;
    end
    check("clear_ready_low", 32'(low_cnt), NAREA);
    check("clear_rsp_edge", 32'(rsp_edge), NAREA);
    for (int i = 0; i < NAREA; i++) issue(OP_READ, 0, IW'(i), 0, 1'b0, 12'd0);
    issue(OP_SIZE, 0, 0, 0, 1'b0, 12'd0);
    issue(OP_WRITE, 0, 1, 12'h055, 1'b0, 12'h055);
    issue(OP_SIZE, 0, 0, 0, 1'b0, 12'd2);
    issue(OP_READ, 0, 5, 0, 1'b0, 12'd0);
    idle(2);

    // Asynchronous reset three cycles into a CLEAR.
    issue(OP_CLEAR, 0, 0, 0, 1'b0, 12'd0);
    idle(3);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_rsp_data", 32'(rsp_data), 0);
    check("mid_rst_rsp_error", 32'(rsp_error), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_allocs", 32'(allocs), 0);
    check("mid_rst_free", 32'(free_count), 0);
    check("mid_rst_state", 32'(fsm_state), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_allocs", 32'(allocs), 0);
    check("post_rst_free", 32'(free_count), 0);
    issue(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0);
    idle(1);
    check("post_rst_allocs_1", 32'(allocs), 1);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
